// File: rtl/rotary_bank_if.sv
// Sequencer-side bus of rotary_bank: output-register instruction in, selected-channel status out.
interface rotary_bank_if #(
  parameter int COUNT_WIDTH = 8
);
  logic [11:0]            inst;
  logic                   inst_en;
  logic                   rotary_left_status;
  logic                   rotary_right_status;
  logic [COUNT_WIDTH-1:0] rotary_count;
  logic [3:0]             rotary_sel;

  modport master (
    output inst, inst_en,
    input  rotary_left_status, rotary_right_status, rotary_count, rotary_sel
  );

  modport slave (
    input  inst, inst_en,
    output rotary_left_status, rotary_right_status, rotary_count, rotary_sel
  );
endinterface

// File: rtl/rotary_bank.sv
// rotary_bank: CHANNELS quadrature encoders -> sync, debounce, step detect, sticky flags + counters.
// Optional `ROTARY_BANK_IRQ_EN adds the irq output, an 8-bit mask register and opcode 0x5.
module rotary_bank #(
  parameter int CHANNELS    = 4,
  parameter int DEBOUNCE    = 16,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  rotary_bank_if.slave          bus,
  input  logic [2*CHANNELS-1:0] rotary
`ifdef ROTARY_BANK_IRQ_EN
  ,
  output logic                  irq
`endif
);

  typedef enum logic [3:0] {
    OP_NOP      = 4'h0,
    OP_SELECT   = 4'h1,
    OP_CLEAR    = 4'h2,
    OP_CLEARALL = 4'h3,
    OP_CLRFLAGS = 4'h4,
    OP_IRQMASK  = 4'h5
  } op_e;

  localparam int                     PW       = 2 * CHANNELS;
  localparam int                     DW       = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0]          DEB_MAX  = DW'(DEBOUNCE);
  localparam logic [DW-1:0]          DEB_ONE  = DW'(1);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);
  localparam logic [8:0]             CH_LIMIT = 9'(CHANNELS);

  logic [PW-1:0]          sync1, sync2, deb_last, acc, acc_next;
  logic [DW-1:0]          deb_cnt  [CHANNELS];
  logic [DW-1:0]          cnt_next [CHANNELS];
  logic [CHANNELS-1:0]    accept, step_r, step_l, sel_hit, clr_cnt, clr_flg;
  logic [CHANNELS-1:0]    left, right, left_next, right_next;
  logic [COUNT_WIDTH-1:0] count      [CHANNELS];
  logic [COUNT_WIDTH-1:0] count_next [CHANNELS];
  logic [3:0]             sel, sel_next;
  logic                   sel_left, sel_right;
  logic [COUNT_WIDTH-1:0] sel_count;
  op_e                    op;
  logic [7:0]             imm;
  logic                   do_clear, do_clearall, do_clrflags;

  assign op          = op_e'(bus.inst[11:8]);
  assign imm         = bus.inst[7:0];
  assign do_clear    = bus.inst_en && (op == OP_CLEAR);
  assign do_clearall = bus.inst_en && (op == OP_CLEARALL);
  assign do_clrflags = bus.inst_en && (op == OP_CLRFLAGS);
  // Out-of-range channel numbers leave the selection untouched.
  assign sel_next    = (bus.inst_en && (op == OP_SELECT) && ({1'b0, imm} < CH_LIMIT))
                       ? imm[3:0] : sel;

  always_comb begin
    // NOTE: every signal driven here gets a default before any conditional, so no latch is inferred.
    acc_next  = acc;
    accept    = '0;
    step_r    = '0;
    step_l    = '0;
    sel_hit   = '0;
    clr_cnt   = '0;
    clr_flg   = '0;
    left_next = left;
    right_next = right;
    sel_left  = 1'b0;
    sel_right = 1'b0;
    sel_count = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      // Run length of the synchronised pair; a new value restarts the run at one sample.
      if (sync2[2*n +: 2] != deb_last[2*n +: 2]) cnt_next[n] = DEB_ONE;
      else if (deb_cnt[n] == DEB_MAX)            cnt_next[n] = DEB_MAX;
      else                                       cnt_next[n] = deb_cnt[n] + DEB_ONE;

      accept[n] = (cnt_next[n] == DEB_MAX) && (sync2[2*n +: 2] != acc[2*n +: 2]);
      step_r[n] = accept[n] && (acc[2*n +: 2] == 2'b01) && (sync2[2*n +: 2] == 2'b11);
      step_l[n] = accept[n] && (acc[2*n +: 2] == 2'b10) && (sync2[2*n +: 2] == 2'b11);
      if (accept[n]) acc_next[2*n +: 2] = sync2[2*n +: 2];

      sel_hit[n] = (sel == 4'(n));
      clr_cnt[n] = do_clearall || (do_clear && sel_hit[n]);
      clr_flg[n] = clr_cnt[n] || (do_clrflags && sel_hit[n]);

      // Clear is applied first so a step landing on the same edge survives it.
      left_next[n]  = (left[n]  && !clr_flg[n]) || step_l[n];
      right_next[n] = (right[n] && !clr_flg[n]) || step_r[n];
      count_next[n] = clr_cnt[n] ? '0 : count[n];
      if (step_r[n])      count_next[n] = count_next[n] + CNT_ONE;
      else if (step_l[n]) count_next[n] = count_next[n] - CNT_ONE;

      if (sel_hit[n]) begin
        sel_left  = left[n];
        sel_right = right[n];
        sel_count = count[n];
      end
    end
  end

`ifdef ROTARY_BANK_IRQ_EN
  localparam int MW = (CHANNELS < 8) ? CHANNELS : 8;

  logic [MW-1:0] irq_mask;
  logic          irq_next;

  always_comb begin
    irq_next = 1'b0;
    for (int n = 0; n < MW; n++) irq_next = irq_next | (irq_mask[n] & (left[n] | right[n]));
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the per-channel arrays are a handful of flops, not RAM, so they are reset in full.
      sync1    <= '1;
      sync2    <= '1;
      deb_last <= '1;
      acc      <= '1;
      for (int n = 0; n < CHANNELS; n++) begin
        deb_cnt[n] <= DEB_MAX;
        count[n]   <= '0;
      end
      left  <= '0;
      right <= '0;
      sel   <= '0;
      bus.rotary_left_status  <= 1'b0;
      bus.rotary_right_status <= 1'b0;
      bus.rotary_count        <= '0;
      bus.rotary_sel          <= '0;
`ifdef ROTARY_BANK_IRQ_EN
      irq_mask <= '0;
      irq      <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      sync1    <= rotary;
      sync2    <= sync1;
      deb_last <= sync2;
      acc      <= acc_next;
      for (int n = 0; n < CHANNELS; n++) begin
        deb_cnt[n] <= cnt_next[n];
        count[n]   <= count_next[n];
      end
      left  <= left_next;
      right <= right_next;
      sel   <= sel_next;
      bus.rotary_left_status  <= sel_left;
      bus.rotary_right_status <= sel_right;
      bus.rotary_count        <= sel_count;
      bus.rotary_sel          <= sel;
`ifdef ROTARY_BANK_IRQ_EN
      if (bus.inst_en && (op == OP_IRQMASK)) irq_mask <= imm[MW-1:0];
      irq <= irq_next;
`endif
    end
  end

endmodule
